led_ring_ctrl: RTL

LED_RING_CTRL -- requirements
Module: led_ring_ctrl

---
 rtl/led_ring_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/led_ring_ctrl.sv
// Three-button LED ring controller: sync + debounce per button, step/dir/mode state, optional auto-repeat.
// Step latency DEB_CNT+3 edges from raw change; no backpressure (raw button inputs, free-running outputs).
module led_ring_ctrl #(
  parameter int N_LED   = 4,
  parameter int DEB_CNT = 16,
  parameter int RPT_EN  = 1,
  parameter int RPT_DLY = 64,
  parameter int RPT_PER = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     but_step,
  input  logic                     but_dir,
  input  logic                     but_mode,
  output logic [N_LED-1:0]         led_o,
  output logic [$clog2(N_LED)-1:0] pos_o,
  output logic                     dir_o,
  output logic                     mode_o,
  output logic                     step_o
);

  localparam int PW = $clog2(N_LED);
  localparam int DW = $clog2(DEB_CNT + 1);

  // Channel order in all 3-bit vectors: [0] step, [1] dir, [2] mode.
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d, deb_dly_q;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];
  logic [2:0]    press;
  logic          rpt_evt;
  logic          step_evt;
  logic [PW-1:0] pos_q, pos_d;
  logic          dir_q, dir_d;
  logic          mode_q, mode_d;
  logic          step_q;

  assign raw = {but_mode, but_dir, but_step};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int c = 0; c < 3; c++) cnt_q[c] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int c = 0; c < 3; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  // A level change is accepted only after DEB_CNT consecutive mismatching cycles.
  always_comb begin
    deb_d = deb_q;
    for (int c = 0; c < 3; c++) begin
      cnt_d[c] = '0;
      if (sync2_q[c] != deb_q[c]) begin
        if (cnt_q[c] == DW'(DEB_CNT - 1)) deb_d[c] = sync2_q[c];
        else                              cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  assign press = deb_q & ~deb_dly_q;

  if (RPT_EN != 0) begin : g_rpt
    localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] hold_q, hold_d;
    logic          act_q, act_d;

    // Down-counter reaching zero marks a repeat; reloaded with the period after each one.
    always_comb begin
      hold_d  = hold_q;
      act_d   = act_q;
      rpt_evt = 1'b0;
      if (!deb_q[0]) begin
        hold_d = '0;
        act_d  = 1'b0;
      end else if (press[0]) begin
        hold_d = RW'(RPT_DLY - 1);
        act_d  = 1'b1;
      end else if (act_q) begin
        if (hold_q == '0) begin
          rpt_evt = 1'b1;
          hold_d  = RW'(RPT_PER - 1);
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        hold_q <= '0;
        act_q  <= 1'b0;
      end else begin
        hold_q <= hold_d;
        act_q  <= act_d;
      end
    end
  end else begin : g_no_rpt
    assign rpt_evt = 1'b0;
  end

  // Step uses the current dir_q, so a same-cycle dir press only affects later steps.
  always_comb begin
    step_evt = press[0] | rpt_evt;
    pos_d    = pos_q;
    if (step_evt) begin
      if (!dir_q) pos_d = (pos_q == PW'(N_LED - 1)) ? '0 : pos_q + 1'b1;
      else        pos_d = (pos_q == '0) ? PW'(N_LED - 1) : pos_q - 1'b1;
    end
    dir_d  = dir_q ^ press[1];
    mode_d = mode_q ^ press[2];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos_q  <= '0;
      dir_q  <= 1'b0;
      mode_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      step_q <= step_evt;
    end
  end

  always_comb begin
    led_o = '0;
    for (int i = 0; i < N_LED; i++) begin
      led_o[i] = mode_q ? (i <= int'(pos_q)) : (i == int'(pos_q));
    end
  end

  assign pos_o  = pos_q;
  assign dir_o  = dir_q;
  assign mode_o = mode_q;
  assign step_o = step_q;

endmodule
